// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//   Y86-64 PIPE memory stage. It holds the M pipeline register, a byte-addressed
//   little-endian data memory and the W pipeline register. The m_valM and m_stat
//   outputs are combinational and are computed from the M register contents.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   M_bubble          load a bubble into M instead of the e_* inputs
//   W_stall           hold the W register (wins over every other W update)
//   e_stat/e_icode/e_cnd/e_valE/e_valA/e_dstE/e_dstM   execute-stage results
//   M_*               M register contents
//   m_valM, m_stat    combinational read data and stage status
//   W_*               W register contents
//
// Handshake note: this stage has no valid/ready handshake. Every register
// advances on every clock edge. M_bubble and W_stall are the only flow
// controls, and each one acts on its own register only.
//
// MEM_BYTES is assumed to be a power of two. An in-range access then never
// wraps the byte index.
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_bubble,
  input  logic        W_stall,
  input  logic [2:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  localparam int AW = $clog2(MEM_BYTES);
  // Highest legal base address of an 8-byte word.
  localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;

  // M register
  logic [2:0]  r_m_stat;
  logic [3:0]  r_m_icode;
  logic        r_m_cnd;
  logic [63:0] r_m_vale;
  logic [63:0] r_m_vala;
  logic [3:0]  r_m_dste;
  logic [3:0]  r_m_dstm;

  // W register
  logic [2:0]  r_w_stat;
  logic [3:0]  r_w_icode;
  logic [63:0] r_w_vale;
  logic [63:0] r_w_valm;
  logic [3:0]  r_w_dste;
  logic [3:0]  r_w_dstm;

  // Data memory. It is not reset, so its contents survive rst.
  logic [7:0]  r_mem [0:MEM_BYTES-1];

  logic          w_is_write;
  logic          w_is_read;
  logic [63:0]   w_addr;
  logic          w_dmem_error;
  logic [AW-1:0] w_base;
  logic [63:0]   w_rdata;
  logic          w_wr_en;
  logic [63:0]   w_valm;
  logic [2:0]    w_stat;

  // Access decode
  always_comb begin
    w_is_write = (r_m_icode == I_RMMOVQ) || (r_m_icode == I_PUSHQ) ||
                 (r_m_icode == I_CALL);
    w_is_read  = (r_m_icode == I_MRMOVQ) || (r_m_icode == I_POPQ) ||
                 (r_m_icode == I_RET);
    // popq and ret take their address from valA. All other accesses use valE.
    w_addr     = ((r_m_icode == I_POPQ) || (r_m_icode == I_RET)) ? r_m_vala : r_m_vale;
    // Full 64-bit unsigned compare, so a huge address can never alias low memory.
    w_dmem_error = (w_is_write || w_is_read) && (w_addr > LAST_OK);
    w_base     = w_addr[AW-1:0];
  end

  // Combinational little-endian read. If a write to the same word happens in
  // this cycle, the read still sees the old data, because the write only
  // lands at the next edge.
  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      w_rdata[8*k +: 8] = r_mem[w_base + AW'(k)];
    end
  end

  always_comb begin
    w_valm = (w_is_read && !w_dmem_error) ? w_rdata : 64'd0;
    w_stat = w_dmem_error ? STAT_ADR : r_m_stat;
    // A store is dropped once an exception has reached writeback.
    w_wr_en = w_is_write && !w_dmem_error && (r_m_stat == STAT_AOK) &&
              (r_w_stat == STAT_AOK);
  end

  // Memory write: all 8 bytes commit together. No write happens on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      for (int k = 0; k < 8; k++) begin
        r_mem[w_base + AW'(k)] <= r_m_vala[8*k +: 8];
      end
    end
  end

  // M register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_stat  <= STAT_AOK;
      r_m_icode <= I_NOP;
      r_m_cnd   <= 1'b0;
      r_m_vale  <= '0;
      r_m_vala  <= '0;
      r_m_dste  <= REG_NONE;
      r_m_dstm  <= REG_NONE;
    end else if (M_bubble) begin
      r_m_stat  <= STAT_AOK;
      r_m_icode <= I_NOP;
      r_m_cnd   <= 1'b0;
      r_m_vale  <= '0;
      r_m_vala  <= '0;
      r_m_dste  <= REG_NONE;
      r_m_dstm  <= REG_NONE;
    end else begin
      r_m_stat  <= e_stat;
      r_m_icode <= e_icode;
      r_m_cnd   <= e_cnd;
      r_m_vale  <= e_valE;
      r_m_vala  <= e_valA;
      r_m_dste  <= e_dstE;
      r_m_dstm  <= e_dstM;
    end
  end

  // W register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_stat  <= STAT_AOK;
      r_w_icode <= I_NOP;
      r_w_vale  <= '0;
      r_w_valm  <= '0;
      r_w_dste  <= REG_NONE;
      r_w_dstm  <= REG_NONE;
    end else if (!W_stall) begin
      r_w_stat  <= w_stat;
      r_w_icode <= r_m_icode;
      r_w_vale  <= r_m_vale;
      r_w_valm  <= w_valm;
      r_w_dste  <= r_m_dste;
      r_w_dstm  <= r_m_dstm;
    end
  end

  assign M_stat  = r_m_stat;
  assign M_icode = r_m_icode;
  assign M_cnd   = r_m_cnd;
  assign M_valE  = r_m_vale;
  assign M_valA  = r_m_vala;
  assign M_dstE  = r_m_dste;
  assign M_dstM  = r_m_dstm;
  assign m_valM  = w_valm;
  assign m_stat  = w_stat;
  assign W_stat  = r_w_stat;
  assign W_icode = r_w_icode;
  assign W_valE  = r_w_vale;
  assign W_valM  = r_w_valm;
  assign W_dstE  = r_w_dste;
  assign W_dstM  = r_w_dstm;

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
//   Directed test of memory_stage. The stimulus code pushes expected values
//   into a queue. A monitor pops the queue and compares at every falling
//   clock edge.
// -----------------------------------------------------------------------------
module tb_memory_stage;

  localparam int MEM_BYTES = 1024;
  localparam int NWORDS    = MEM_BYTES / 8;

  // observable selectors
  localparam int S_M_STAT  = 0;
  localparam int S_M_ICODE = 1;
  localparam int S_M_CND   = 2;
  localparam int S_M_VALE  = 3;
  localparam int S_M_VALA  = 4;
  localparam int S_M_DSTE  = 5;
  localparam int S_M_DSTM  = 6;
  localparam int S_MVALM   = 7;
  localparam int S_MSTAT   = 8;
  localparam int S_W_STAT  = 9;
  localparam int S_W_ICODE = 10;
  localparam int S_W_VALE  = 11;
  localparam int S_W_VALM  = 12;
  localparam int S_W_DSTE  = 13;
  localparam int S_W_DSTM  = 14;
  localparam int S_BYTE16  = 15;

  logic        clk;
  logic        rst;
  logic        M_bubble;
  logic        W_stall;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode;
  logic        e_cnd;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [63:0] m_valM;
  logic [2:0]  m_stat;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;

  memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .M_bubble(M_bubble), .W_stall(W_stall),
    .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd), .e_valE(e_valE),
    .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_valM(m_valM), .m_stat(m_stat),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad   = 0;

  // bench-side image of data memory, one entry per 8-byte word
  logic [63:0] model_word [0:NWORDS-1];

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      S_M_STAT:  observe = 64'(M_stat);
      S_M_ICODE: observe = 64'(M_icode);
      S_M_CND:   observe = 64'(M_cnd);
      S_M_VALE:  observe = M_valE;
      S_M_VALA:  observe = M_valA;
      S_M_DSTE:  observe = 64'(M_dstE);
      S_M_DSTM:  observe = 64'(M_dstM);
      S_MVALM:   observe = m_valM;
      S_MSTAT:   observe = 64'(m_stat);
      S_W_STAT:  observe = 64'(W_stat);
      S_W_ICODE: observe = 64'(W_icode);
      S_W_VALE:  observe = W_valE;
      S_W_VALM:  observe = W_valM;
      S_W_DSTE:  observe = 64'(W_dstE);
      S_W_DSTM:  observe = 64'(W_dstM);
      S_BYTE16:  observe = 64'(dut.r_mem[16]);
      default:   observe = 64'hx;
    endcase
  endfunction

  // monitor: compare every pending expectation at the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      logic [63:0] a;
      int          s;
      string       n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      a = observe(s);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_v(input string nm, input int sel, input logic [63:0] v);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_e(input logic [3:0] icode, input logic [63:0] vale,
                         input logic [63:0] vala, input logic [3:0] dste,
                         input logic [3:0] dstm);
    e_stat  = 3'd1;
    e_icode = icode;
    e_valE  = vale;
    e_valA  = vala;
    e_dstE  = dste;
    e_dstM  = dstm;
  endtask

  task automatic nop_e();
    drive_e(4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; M_bubble = 1'b0; W_stall = 1'b0; e_cnd = 1'b0;
    nop_e();

    // reset state
    expect_v("rst_M_stat",  S_M_STAT,  64'd1);
    expect_v("rst_M_icode", S_M_ICODE, 64'd1);
    expect_v("rst_M_cnd",   S_M_CND,   64'd0);
    expect_v("rst_M_valE",  S_M_VALE,  64'd0);
    expect_v("rst_M_dstE",  S_M_DSTE,  64'hF);
    expect_v("rst_W_stat",  S_W_STAT,  64'd1);
    expect_v("rst_W_icode", S_W_ICODE, 64'd1);
    expect_v("rst_W_valM",  S_W_VALM,  64'd0);
    expect_v("rst_W_dstM",  S_W_DSTM,  64'hF);
    expect_v("rst_m_valM",  S_MVALM,   64'd0);
    sample();
    step();
    rst = 1'b0;

    // preload all of memory through back-to-back rmmovq stores
    for (int k = 0; k < NWORDS; k++) begin
      model_word[k] = 64'h0F0E_0D0C_0000_0000 + 64'(k * 3 + 1);
      drive_e(4'h4, 64'(k * 8), model_word[k], 4'hF, 4'hF);
      step();
    end
    nop_e();
    step();

    // rmmovq 16 then mrmovq 16
    drive_e(4'h4, 64'd16, 64'h1122334455667788, 4'hF, 4'hF);
    step();
    expect_v("st_M_icode", S_M_ICODE, 64'd4);
    expect_v("st_M_valE",  S_M_VALE,  64'd16);
    expect_v("st_M_valA",  S_M_VALA,  64'h1122334455667788);
    expect_v("st_m_valM",  S_MVALM,   64'd0);
    expect_v("st_m_stat",  S_MSTAT,   64'd1);
    sample();
    drive_e(4'h5, 64'd16, 64'd0, 4'hF, 4'd2);
    step();
    model_word[2] = 64'h1122334455667788;
    expect_v("ld16_m_valM", S_MVALM,   64'h1122334455667788);
    expect_v("ld16_byte16", S_BYTE16,  64'h88);
    expect_v("ld16_W_icode", S_W_ICODE, 64'd4);
    sample();
    nop_e();
    step();
    expect_v("ld16_W_valM", S_W_VALM,  64'h1122334455667788);
    expect_v("ld16_W_dstM", S_W_DSTM,  64'd2);
    expect_v("ld16_W_icode", S_W_ICODE, 64'd5);
    sample();

    // popq at the last legal word, then one byte beyond
    drive_e(4'hB, 64'd1024, 64'(MEM_BYTES - 8), 4'd4, 4'd5);
    step();
    expect_v("pop_ok_m_stat", S_MSTAT, 64'd1);
    expect_v("pop_ok_m_valM", S_MVALM, model_word[NWORDS-1]);
    sample();
    drive_e(4'hB, 64'd1024, 64'(MEM_BYTES - 7), 4'd4, 4'd5);
    step();
    expect_v("pop_ok_W_valM", S_W_VALM, model_word[NWORDS-1]);
    expect_v("pop_ok_W_stat", S_W_STAT, 64'd1);
    expect_v("pop_ok_W_dstM", S_W_DSTM, 64'd5);
    expect_v("pop_bad_m_stat", S_MSTAT, 64'd3);
    expect_v("pop_bad_m_valM", S_MVALM, 64'd0);
    sample();

    // pushq to 32 while the ADR status sits in W: store is suppressed
    drive_e(4'hA, 64'd32, 64'hDEADBEEFCAFEF00D, 4'd4, 4'hF);
    step();
    expect_v("pop_bad_W_stat", S_W_STAT,  64'd3);
    expect_v("push1_M_icode",  S_M_ICODE, 64'hA);
    expect_v("push1_m_stat",   S_MSTAT,   64'd1);
    sample();
    nop_e();
    step();
    expect_v("push1_W_stat",  S_W_STAT,  64'd1);
    expect_v("push1_W_icode", S_W_ICODE, 64'hA);
    sample();
    drive_e(4'h5, 64'd32, 64'd0, 4'hF, 4'd6);
    step();
    expect_v("push1_unchanged", S_MVALM, model_word[4]);
    sample();
    // same pushq with W_stat=AOK: store happens
    drive_e(4'hA, 64'd32, 64'hDEADBEEFCAFEF00D, 4'd4, 4'hF);
    step();
    drive_e(4'h5, 64'd32, 64'd0, 4'hF, 4'd6);
    step();
    model_word[4] = 64'hDEADBEEFCAFEF00D;
    expect_v("push2_written", S_MVALM, model_word[4]);
    sample();

    // rmmovq to 0xFFFFFFFFFFFFFFF8: error, and the low-address alias stays intact
    drive_e(4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'h55, 4'hF, 4'hF);
    step();
    expect_v("big_m_stat", S_MSTAT, 64'd3);
    expect_v("big_m_valM", S_MVALM, 64'd0);
    sample();
    nop_e();
    step();
    expect_v("big_W_stat", S_W_STAT, 64'd3);
    sample();
    drive_e(4'h5, 64'(MEM_BYTES - 8), 64'd0, 4'hF, 4'd1);
    step();
    expect_v("big_no_write", S_MVALM,  model_word[NWORDS-1]);
    expect_v("big_W_clear",  S_W_STAT, 64'd1);
    sample();

    // opq: no memory access, cnd carried through M
    e_cnd = 1'b1;
    drive_e(4'h6, 64'd16, 64'd0, 4'd3, 4'hF);
    step();
    e_cnd = 1'b0;
    expect_v("opq_m_valM", S_MVALM,  64'd0);
    expect_v("opq_m_stat", S_MSTAT,  64'd1);
    expect_v("opq_M_cnd",  S_M_CND,  64'd1);
    expect_v("opq_M_dstE", S_M_DSTE, 64'd3);
    sample();

    // call writes valA at valE, then ret reads it back through valA
    drive_e(4'h8, 64'd40, 64'h0123456789ABCDEF, 4'd4, 4'hF);
    step();
    drive_e(4'h9, 64'd48, 64'd40, 4'd4, 4'hF);
    step();
    model_word[5] = 64'h0123456789ABCDEF;
    expect_v("ret_m_valM", S_MVALM, model_word[5]);
    sample();

    // W_stall holds opq in W while M keeps loading; M_bubble alongside
    drive_e(4'h6, 64'd80, 64'd0, 4'd3, 4'hF);
    step();
    drive_e(4'h3, 64'd7, 64'd0, 4'd1, 4'hF);
    step();
    expect_v("stl0_W_valE", S_W_VALE, 64'd80);
    expect_v("stl0_W_dstE", S_W_DSTE, 64'd3);
    sample();
    W_stall = 1'b1;
    drive_e(4'h2, 64'd9, 64'd0, 4'd2, 4'hF);
    step();
    expect_v("stl1_W_valE",  S_W_VALE,  64'd80);
    expect_v("stl1_W_icode", S_W_ICODE, 64'd6);
    expect_v("stl1_M_icode", S_M_ICODE, 64'd2);
    expect_v("stl1_M_valE",  S_M_VALE,  64'd9);
    sample();
    M_bubble = 1'b1;
    drive_e(4'h6, 64'd99, 64'd0, 4'd5, 4'hF);
    step();
    expect_v("stl2_W_valE",  S_W_VALE,  64'd80);
    expect_v("stl2_W_dstE",  S_W_DSTE,  64'd3);
    expect_v("bub_M_icode",  S_M_ICODE, 64'd1);
    expect_v("bub_M_dstE",   S_M_DSTE,  64'hF);
    expect_v("bub_M_valE",   S_M_VALE,  64'd0);
    sample();
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    nop_e();
    step();
    expect_v("unstl_W_icode", S_W_ICODE, 64'd1);
    expect_v("unstl_W_valE",  S_W_VALE,  64'd0);
    expect_v("unstl_W_dstE",  S_W_DSTE,  64'hF);
    sample();

    // reset mid-stream: registers clear at once, memory keeps committed data
    drive_e(4'h6, 64'd5, 64'd0, 4'd2, 4'hF);
    step();
    drive_e(4'h5, 64'd40, 64'd0, 4'hF, 4'd7);
    step();
    rst = 1'b1;
    #1;
    expect_v("mrst_M_icode", S_M_ICODE, 64'd1);
    expect_v("mrst_W_icode", S_W_ICODE, 64'd1);
    expect_v("mrst_M_dstE",  S_M_DSTE,  64'hF);
    expect_v("mrst_W_dstM",  S_W_DSTM,  64'hF);
    expect_v("mrst_W_stat",  S_W_STAT,  64'd1);
    expect_v("mrst_W_valE",  S_W_VALE,  64'd0);
    sample();
    step();
    rst = 1'b0;
    drive_e(4'h5, 64'd40, 64'd0, 4'hF, 4'd7);
    step();
    expect_v("mrst_mem_kept", S_MVALM, model_word[5]);
    sample();
    nop_e();
    step();
    sample();

    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      bad += exp_q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish by 50000");
    $fatal(1);
  end

endmodule
